// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Shared definitions for the I2S/TDM transmitter: framing mode encoding, the
// frame-length helper and the parameter-legality predicate used at
// elaboration time.
// ---------------------------------------------------------------------------
package i2s_pkg;

   // Framing mode as presented on the mode input.
   typedef enum logic {
      I2S_MODE_I2S = 1'b0,  // data delayed one bit clock after the lrck edge
      I2S_MODE_LJ  = 1'b1   // data aligned to the lrck edge
   } i2s_mode_e;

   // Bit clocks per complete frame (all slots).
   function automatic int unsigned i2s_frame_bits(input int unsigned channels,
                                                  input int unsigned slot_w);
      return channels * slot_w;
   endfunction

   function automatic bit i2s_is_pow2(input int unsigned x);
      return (x != 0) && ((x & (x - 1)) == 0);
   endfunction

   function automatic bit i2s_params_ok(input int unsigned sample_w,
                                        input int unsigned slot_w,
                                        input int unsigned channels,
                                        input int unsigned fifo_depth);
      return (sample_w >= 1) && (sample_w <= slot_w) &&
             (slot_w >= 8) && (slot_w <= 32) &&
             (channels >= 2) && (channels <= 8) && ((channels % 2) == 0) &&
             (fifo_depth >= 2) && i2s_is_pow2(fifo_depth);
   endfunction

endpackage

// File: rtl/i2s_frame_fifo.sv
// ---------------------------------------------------------------------------
// i2s_frame_fifo
// Synchronous frame FIFO clocked on the falling edge of sclk.
//   sclk   in   bit clock (falling edge active)
//   aclr   in   asynchronous active-high reset; empties the FIFO
//   push   in   write wdata (ignored when full)
//   pop    in   advance the read pointer (ignored when empty)
//   wdata  in   frame to store
//   rdata  out  head frame (valid when not empty)
//   level  out  frames currently held
//   full   out  registered level == DEPTH
//   empty  out  registered level == 0
// ---------------------------------------------------------------------------
module i2s_frame_fifo #(
   parameter int unsigned WIDTH = 48,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     sclk,
   input  logic                     aclr,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] LVL_FULL = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [PTR_W:0]   r_level;
   logic [PTR_W:0]   w_level_d;
   logic             r_full;
   logic             r_empty;
   logic             w_push;
   logic             w_pop;

   assign w_push = push && !r_full;
   assign w_pop  = pop && !r_empty;

   always_comb begin
      w_level_d = r_level;
      if (w_push && !w_pop) begin
         w_level_d = r_level + 1'b1;
      end else if (w_pop && !w_push) begin
         w_level_d = r_level - 1'b1;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(negedge sclk or posedge aclr) begin
      if (aclr) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         r_level <= w_level_d;
         r_full  <= (w_level_d == LVL_FULL);
         r_empty <= (w_level_d == '0);
      end
   end

   // Storage is not reset; the pointers alone define what is valid.
   always_ff @(negedge sclk) begin
      if (w_push) r_mem[r_wptr] <= wdata;
   end

   assign rdata = r_mem[r_rptr];
   assign level = r_level;
   assign full  = r_full;
   assign empty = r_empty;

endmodule

// File: rtl/i2s_tdm_tx.sv
// ---------------------------------------------------------------------------
// i2s_tdm_tx
// I2S / left-justified TDM serial audio transmitter. Frames are queued in a
// small FIFO and serialised MSB first, one slot per channel, zero padded.
//   sclk        in   bit clock; all state updates on the falling edge
//   aclr        in   asynchronous active-high reset
//   mode        in   0 = I2S (one-bit delay), 1 = left-justified
//   in_valid    in   in_data holds a frame
//   in_ready    out  FIFO not full
//   in_data     in   packed frame, channel 0 in the MSBs
//   lrck        out  frame clock, low for the first half of the frame
//   dout        out  serial data
//   underrun    out  one-period pulse at bc=0 of a frame loaded as zeros
//   fifo_level  out  frames buffered
// ---------------------------------------------------------------------------
module i2s_tdm_tx
   import i2s_pkg::*;
#(
   parameter int unsigned SAMPLE_W   = 24,
   parameter int unsigned SLOT_W     = 32,
   parameter int unsigned CHANNELS   = 2,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                           sclk,
   input  logic                           aclr,
   input  logic                           mode,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [CHANNELS*SAMPLE_W-1:0]   in_data,
   output logic                           lrck,
   output logic                           dout,
   output logic                           underrun,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_level
);

   localparam int unsigned FRAME  = i2s_frame_bits(CHANNELS, SLOT_W);
   localparam int unsigned BC_W   = $clog2(FRAME);
   localparam int unsigned DATA_W = CHANNELS * SAMPLE_W;
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(FRAME - 1);
   localparam logic [BC_W-1:0] BC_HALF = BC_W'(FRAME / 2);

   if (!i2s_params_ok(SAMPLE_W, SLOT_W, CHANNELS, FIFO_DEPTH)) begin : g_param_check
      $error("i2s_tdm_tx: illegal SAMPLE_W/SLOT_W/CHANNELS/FIFO_DEPTH combination");
   end

   logic [BC_W-1:0]   r_bc;
   logic [BC_W-1:0]   w_bc_d;
   logic              w_load;
   logic [FRAME-1:0]  r_sr;
   logic [FRAME-1:0]  w_sr_d;
   logic [FRAME-1:0]  w_expanded;
   logic              r_lj;
   logic              w_lj_d;
   logic              r_lrck;
   logic              r_dout;
   logic              r_underrun;
   i2s_mode_e         r_mode;
   i2s_mode_e         w_mode_d;
   logic [DATA_W-1:0] w_rdata;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;

   assign w_load = (r_bc == BC_LAST);
   assign w_push = in_valid && !w_full;
   // A push on the load edge never feeds the load itself: an empty FIFO
   // underruns even if a frame arrives on the same edge.
   assign w_pop  = w_load && !w_empty;

   i2s_frame_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .sclk  (sclk),
      .aclr  (aclr),
      .push  (w_push),
      .pop   (w_pop),
      .wdata (in_data),
      .rdata (w_rdata),
      .level (fifo_level),
      .full  (w_full),
      .empty (w_empty)
   );

   // Place each sample at the top of its slot; the low pad bits stay zero.
   for (genvar c = 0; c < CHANNELS; c++) begin : g_slot
      assign w_expanded[FRAME-1-c*SLOT_W -: SLOT_W] =
         SLOT_W'(w_rdata[DATA_W-1-c*SAMPLE_W -: SAMPLE_W]) << (SLOT_W - SAMPLE_W);
   end

   // r_lj is the left-justified bit for the current period; r_sr holds the
   // bits still to come, next one at the MSB.
   always_comb begin
      w_bc_d   = w_load ? '0 : r_bc + 1'b1;
      w_mode_d = r_mode;
      w_sr_d   = {r_sr[FRAME-2:0], 1'b0};
      w_lj_d   = r_sr[FRAME-1];
      if (w_load) begin
         w_mode_d = i2s_mode_e'(mode);
         if (!w_empty) begin
            w_sr_d = {w_expanded[FRAME-2:0], 1'b0};
            w_lj_d = w_expanded[FRAME-1];
         end else begin
            w_sr_d = '0;
            w_lj_d = 1'b0;
         end
      end
   end

   always_ff @(negedge sclk or posedge aclr) begin
      if (aclr) begin
         r_bc       <= '0;
         r_sr       <= '0;
         r_lj       <= 1'b0;
         r_mode     <= I2S_MODE_I2S;
         r_lrck     <= 1'b0;
         r_dout     <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_bc       <= w_bc_d;
         r_sr       <= w_sr_d;
         r_lj       <= w_lj_d;
         r_mode     <= w_mode_d;
         r_lrck     <= (w_bc_d >= BC_HALF);
         // I2S replays the previous period's left-justified bit, so at bc=0
         // it carries the last bit of the prior frame.
         r_dout     <= (w_mode_d == I2S_MODE_LJ) ? w_lj_d : r_lj;
         r_underrun <= w_load && w_empty;
      end
   end

   assign in_ready = !w_full;
   assign lrck     = r_lrck;
   assign dout     = r_dout;
   assign underrun = r_underrun;

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// ---------------------------------------------------------------------------
// tb_i2s_tdm_tx
// Directed bench for i2s_tdm_tx: default stereo instance (LJ, I2S, underrun,
// fill, mid-frame reset) and an 8-channel 16-bit instance. Outputs are
// sampled on rising sclk edges; the DUT updates on falling edges.
// ---------------------------------------------------------------------------
module tb_i2s_tdm_tx;

   logic         sclk = 1'b0;
   logic         aclr_a, aclr_b;
   logic         mode_a, mode_b;
   logic         in_valid_a, in_valid_b;
   logic         in_ready_a, in_ready_b;
   logic [47:0]  in_data_a;
   logic [127:0] in_data_b;
   logic         lrck_a, lrck_b;
   logic         dout_a, dout_b;
   logic         underrun_a, underrun_b;
   logic [2:0]   fifo_level_a, fifo_level_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 sclk = ~sclk;

   i2s_tdm_tx u_dut_a (
      .sclk       (sclk),
      .aclr       (aclr_a),
      .mode       (mode_a),
      .in_valid   (in_valid_a),
      .in_ready   (in_ready_a),
      .in_data    (in_data_a),
      .lrck       (lrck_a),
      .dout       (dout_a),
      .underrun   (underrun_a),
      .fifo_level (fifo_level_a)
   );

   i2s_tdm_tx #(
      .SAMPLE_W   (16),
      .SLOT_W     (16),
      .CHANNELS   (8),
      .FIFO_DEPTH (4)
   ) u_dut_b (
      .sclk       (sclk),
      .aclr       (aclr_b),
      .mode       (mode_b),
      .in_valid   (in_valid_b),
      .in_ready   (in_ready_b),
      .in_data    (in_data_b),
      .lrck       (lrck_b),
      .dout       (dout_b),
      .underrun   (underrun_b),
      .fifo_level (fifo_level_b)
   );

   task automatic check_eq(input string tag, input logic [127:0] got,
                           input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Record nbits periods starting at the current rising edge (bc=0). Bit
   // nbits-1 of each vector is bc=0. Optionally push one frame at period
   // push_at (it is written on the following falling edge).
   task automatic capture(input bit sel_b, input int nbits, input int push_at,
                          input logic [127:0] pdata, output logic [127:0] d,
                          output logic [127:0] l, output logic [127:0] u);
      d = '0;
      l = '0;
      u = '0;
      for (int i = 0; i < nbits; i++) begin
         d[nbits-1-i] = sel_b ? dout_b : dout_a;
         l[nbits-1-i] = sel_b ? lrck_b : lrck_a;
         u[nbits-1-i] = sel_b ? underrun_b : underrun_a;
         if (i == push_at) begin
            if (sel_b) begin
               in_valid_b = 1'b1;
               in_data_b  = pdata;
            end else begin
               in_valid_a = 1'b1;
               in_data_a  = pdata[47:0];
            end
         end
         @(posedge sclk);
         in_valid_a = 1'b0;
         in_valid_b = 1'b0;
      end
   endtask

   logic [127:0] d, l, u;
   logic [127:0] frm_a, frm_b, frm_d;
   logic [127:0] exp_lj_a, exp_i2s_a, exp_i2s_b, exp_i2s_c0;
   logic [127:0] lrck_exp_a, lrck_exp_b, ur_pulse_a;
   logic [47:0]  c_data [5];

   initial begin
      frm_a      = {80'h0, 24'hA5A5A5, 24'h5A5A5A};
      frm_b      = {80'h0, 24'h123456, 24'hFEDCBA};
      frm_d      = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
      exp_lj_a   = {64'h0, 24'hA5A5A5, 8'h00, 24'h5A5A5A, 8'h00};
      exp_i2s_a  = {64'h0, 1'b0, 24'hA5A5A5, 8'h00, 24'h5A5A5A, 7'h00};
      exp_i2s_b  = {64'h0, 1'b0, 24'h123456, 8'h00, 24'hFEDCBA, 7'h00};
      exp_i2s_c0 = {64'h0, 1'b0, 24'hC0C0C0, 8'h00, 24'hFFFFFF, 7'h00};
      lrck_exp_a = {64'h0, 32'h0, 32'hFFFF_FFFF};
      lrck_exp_b = {64'h0, {64{1'b1}}};
      ur_pulse_a = {64'h0, 1'b1, 63'h0};
      c_data[0]  = {24'hC0C0C0, 24'hFFFFFF};
      c_data[1]  = {24'hC1C1C1, 24'hFFFFFF};
      c_data[2]  = {24'hC2C2C2, 24'hFFFFFF};
      c_data[3]  = {24'hC3C3C3, 24'hFFFFFF};
      c_data[4]  = {24'hC4C4C4, 24'hFFFFFF};

      aclr_a     = 1'b1;
      aclr_b     = 1'b1;
      mode_a     = 1'b1;
      mode_b     = 1'b1;
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
      in_data_a  = '0;
      in_data_b  = '0;

      repeat (3) @(posedge sclk);
      check_eq("rst_lrck", lrck_a, 0);
      check_eq("rst_dout", dout_a, 0);
      check_eq("rst_ready", in_ready_a, 1);
      check_eq("rst_level", fifo_level_a, 0);
      check_eq("rst_underrun", underrun_a, 0);

      // Frame 0: post-reset zero frame, no underrun; A is queued.
      aclr_a = 1'b0;
      capture(1'b0, 64, 0, frm_a, d, l, u);
      check_eq("f0_dout", d, 0);
      check_eq("f0_underrun", u, 0);
      check_eq("f0_lrck", l, lrck_exp_a);
      check_eq("f0_level_after_pop", fifo_level_a, 0);

      // Frame 1: A in LJ; the switch to I2S here applies from frame 2.
      mode_a = 1'b0;
      capture(1'b0, 64, 0, frm_a, d, l, u);
      check_eq("f1_lj_dout", d, exp_lj_a);
      check_eq("f1_lrck", l, lrck_exp_a);
      check_eq("f1_underrun", u, 0);

      // Frame 2: A in I2S, shifted by one period.
      capture(1'b0, 64, -1, '0, d, l, u);
      check_eq("f2_i2s_dout", d, exp_i2s_a);
      check_eq("f2_lrck", l, lrck_exp_a);
      check_eq("f2_underrun", u, 0);

      // Frame 3: empty FIFO; B pushed on the closing load edge.
      capture(1'b0, 64, 63, frm_b, d, l, u);
      check_eq("f3_zero_dout", d, 0);
      check_eq("f3_underrun", u, ur_pulse_a);
      check_eq("f3_push_on_load_level", fifo_level_a, 1);

      // Frame 4: still an underrun, B is not bypassed.
      capture(1'b0, 64, -1, '0, d, l, u);
      check_eq("f4_zero_dout", d, 0);
      check_eq("f4_underrun", u, ur_pulse_a);
      check_eq("f4_level", fifo_level_a, 0);

      // Frame 5: B plays.
      capture(1'b0, 64, -1, '0, d, l, u);
      check_eq("f5_i2s_dout", d, exp_i2s_b);
      check_eq("f5_underrun", u, 0);

      // Frame 6: fill with no drain; the fifth push is refused.
      for (int k = 0; k < 5; k++) begin
         in_valid_a = 1'b1;
         in_data_a  = c_data[k];
         @(posedge sclk);
         check_eq($sformatf("fill_level%0d", k), fifo_level_a, (k < 4) ? k + 1 : 4);
         check_eq($sformatf("fill_ready%0d", k), in_ready_a, (k < 3) ? 1 : 0);
      end
      in_valid_a = 1'b0;
      repeat (59) @(posedge sclk);
      check_eq("drain_level", fifo_level_a, 3);
      check_eq("drain_ready", in_ready_a, 1);

      // Frame 7: first queued frame.
      capture(1'b0, 64, -1, '0, d, l, u);
      check_eq("f7_i2s_dout", d, exp_i2s_c0);
      check_eq("f7_underrun", u, 0);

      // Frame 8: reset at bc=40 with two frames queued.
      repeat (40) @(posedge sclk);
      check_eq("pre_rst_dout", dout_a, 1);
      check_eq("pre_rst_lrck", lrck_a, 1);
      check_eq("pre_rst_level", fifo_level_a, 2);
      aclr_a = 1'b1;
      #1;
      check_eq("midrst_dout", dout_a, 0);
      check_eq("midrst_lrck", lrck_a, 0);
      check_eq("midrst_level", fifo_level_a, 0);
      check_eq("midrst_ready", in_ready_a, 1);
      @(posedge sclk);
      aclr_a = 1'b0;
      capture(1'b0, 64, -1, '0, d, l, u);
      check_eq("postrst_dout", d, 0);
      check_eq("postrst_underrun", u, 0);
      check_eq("postrst_lrck", l, lrck_exp_a);
      capture(1'b0, 64, -1, '0, d, l, u);
      check_eq("postrst2_dout", d, 0);
      check_eq("postrst2_underrun", u, ur_pulse_a);

      // 8-channel, 16-bit slots, LJ.
      aclr_b = 1'b0;
      capture(1'b1, 128, 0, frm_d, d, l, u);
      check_eq("b_f0_dout", d, 0);
      check_eq("b_f0_underrun", u, 0);
      check_eq("b_f0_lrck", l, lrck_exp_b);
      capture(1'b1, 128, -1, '0, d, l, u);
      check_eq("b_f1_dout", d, frm_d);
      check_eq("b_f1_lrck", l, lrck_exp_b);
      check_eq("b_f1_underrun", u, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/i2s_tdm_tx.md
# i2s_tdm_tx

Parametrised I2S/TDM serial audio transmitter, the multichannel successor to the team's fixed 2×32-bit stereo transmitter. Accepts one packed multichannel frame per valid/ready handshake into a small frame FIFO, then serialises it MSB-first on `dout` with a 50%-duty frame clock on `lrck`. It sits between the synth mixer output and the DAC/codec pins, entirely in the `sclk` domain. It supports I2S or left-justified framing, and reports FIFO underrun.

## Interface
- `SAMPLE_W`, 24: bits per channel sample; 1..`SLOT_W`.
- `SLOT_W`, 32: bit clocks per channel slot; 8..32.
- `CHANNELS`, 2: slots per frame; even, 2..8. A value of 2 is plain stereo I2S.
- `FIFO_DEPTH`, 4: frames buffered; power of two, ≥2.
- `sclk`  in  1  bit clock; all registers update on its falling edge.
- `aclr`  in  1  reset, asynchronous, active-high.
- `mode`  in  1  0 = I2S (one-bit delay after `lrck` edge), 1 = left-justified.
- `in_valid`  in  1  `in_data` holds a frame.
- `in_ready`  out  1  FIFO not full.
- `in_data`  in  `CHANNELS*SAMPLE_W`  packed frame; channel 0 in the MSBs.
- `lrck`  out  1  frame/word clock.
- `dout`  out  1  serial data.
- `underrun`  out  1  one-cycle pulse when a frame load finds the FIFO empty.
- `fifo_level`  out  `$clog2(FIFO_DEPTH)+1`  frames currently buffered.

## Operation
- FRAME = `CHANNELS*SLOT_W`. Bit counter `bc` runs 0..FRAME-1 and wraps to 0.
- `lrck` = 0 for `bc` < FRAME/2 and 1 otherwise. With `CHANNELS` = 2, left = low and right = high.
- Slot layout: slot c occupies `bc` c*SLOT_W..c*SLOT_W+SLOT_W-1. The sample is sent MSB first, then SLOT_W-SAMPLE_W zero bits.
- Frame bit index f: f = `bc` when `mode`=1; f = `bc`-1 when `mode`=0. In I2S mode, period `bc`=0 carries the last bit of the previous frame (always a pad bit or sample LSB).
- Frame load at `bc` = FRAME-1:
  - If the FIFO is non-empty, pop the head frame into the shift register.
  - If the FIFO is empty, load all-zeros and pulse `underrun`.
- `mode` is sampled only at the frame-load edge. A mid-frame change has no effect until the next frame.
- Push when `in_valid` && `in_ready`. The data is written at that falling edge.
- Simultaneous push and pop:
  - `fifo_level` is unchanged.
  - If the FIFO was empty, the pop still underruns (the new frame is not bypassed), and `fifo_level` becomes 1.
- `in_ready` = (`fifo_level` != FIFO_DEPTH), registered. When full, a push is refused even if a pop occurs on the same edge.
- Reset values: `bc`=0, `lrck`=0, `dout`=0, shift register=0, FIFO empty, `fifo_level`=0, `in_ready`=1, `underrun`=0.
- Reset mid-frame aborts the frame immediately and discards FIFO contents. The first post-reset frame outputs zeros with no `underrun`. The first load occurs at the end of that frame.

## Timing
- `lrck` and `dout` change only on falling `sclk` edges. The receiver samples on rising edges.
- `lrck` toggles at the edges entering `bc`=0 and `bc`=FRAME/2.
- Latency from accept to first output:
  - Earliest: the frame-load edge that follows acceptance.
  - The frame's MSB appears on `dout` in period `bc`=0 (LJ) or `bc`=1 (I2S) of the next frame.
- `underrun` is high for exactly one `sclk` period, coincident with `bc`=0 of the zero frame.
- `fifo_level` and `in_ready` reflect the push/pop of the same edge.

## Structure
- Package `i2s_pkg`:
  - Mode constants `I2S_MODE_I2S`=0 and `I2S_MODE_LJ`=1.
  - Function `i2s_frame_bits(CHANNELS, SLOT_W)`.
  - Parameter-legality checks (SAMPLE_W ≤ SLOT_W, even CHANNELS, power-of-two FIFO_DEPTH).
- Sub-module `i2s_frame_fifo`:
  - Synchronous FIFO of width `CHANNELS*SAMPLE_W` and depth `FIFO_DEPTH`, on negedge `sclk` with `aclr`.
  - Ports: push, pop, wdata, rdata, level, full, empty.
- Top level: bit counter, `lrck` decode, slot/pad expansion into a FRAME-bit shift register, I2S delay flop, and underrun pulse.

## Test plan
- Defaults, LJ: push L=24'hA5A5A5, R=24'h5A5A5A → next frame's `dout` matches bit-for-bit; bits 24..31 of each slot are 0; `lrck` low for 32 bits, then high for 32.
- Defaults, I2S: same frame → identical pattern shifted one `sclk` later; MSB of L appears at `bc`=1, and R's last pad bit appears at `bc`=0 of the following frame.
- CHANNELS=8, SLOT_W=16, SAMPLE_W=16, channel c = 16'h1111*c → eight slots in order; `lrck` high for `bc` 64..127.
- Fill: hold `in_valid` high with no drain for 4 pushes → `in_ready`=0, `fifo_level`=4, and a 5th frame is not accepted; one frame later `in_ready`=1 and `fifo_level`=3.
- Empty FIFO → all-zero frame; `underrun` high for exactly one period at `bc`=0; push on the load edge gives `fifo_level`=1 and that frame plays next.
- `aclr` asserted at `bc`=40 with 2 frames queued → outputs zero immediately, `fifo_level`=0, and the first post-reset frame is zeros with no `underrun`.
